// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute-stage request/response and memory bus bundle for the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_fault,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_fault,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit, one op in flight, REQ/WAIT bus handshake with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e      state_q;
    logic        req_ready_q, mem_req_q, mem_we_q, resp_valid_q, resp_fault_q;
    logic [31:0] resp_data_q, mem_addr_q, mem_wdata_q, cnt_q;
    logic [3:0]  mem_wstrb_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        size_b, size_h, size_w, reject_d, timed_out;
    logic [1:0]  off_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d, load_d;
    logic [15:0] lane;

    always_comb begin
        size_b   = (bus.req_funct3[1:0] == 2'b00);
        size_h   = (bus.req_funct3[1:0] == 2'b01);
        size_w   = (bus.req_funct3[1:0] == 2'b10);
        reject_d = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        reject_d = reject_d || (size_h && bus.req_addr[0])
                            || (size_w && (bus.req_addr[1:0] != 2'b00));
`endif
        // Offending low bits are dropped so the lane matches the natural alignment.
        off_d   = size_w ? 2'b00 : (size_h ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);
        wstrb_d = 4'b0000;
        wdata_d = 32'h0;
        if (bus.req_we) begin
            if (size_b) begin
                wstrb_d = 4'b0001 << off_d;
                wdata_d = {4{bus.req_wdata[7:0]}};
            end else if (size_h) begin
                wstrb_d = off_d[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.req_wdata[15:0]}};
            end else begin
                wstrb_d = 4'b1111;
                wdata_d = bus.req_wdata;
            end
        end
    end

    always_comb begin
        lane = 16'(bus.mem_rdata >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_d = {24'h0, lane[7:0]};
            3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_d = {16'h0, lane[15:0]};
            default: load_d = bus.mem_rdata;
        endcase
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_data_q  <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
            cnt_q        <= 32'h0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        funct3_q    <= bus.req_funct3;
                        off_q       <= off_d;
                        cnt_q       <= 32'h0;
                        mem_we_q    <= bus.req_we;
                        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_q <= wstrb_d;
                        mem_wdata_q <= wdata_d;
                        if (reject_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_data_q  <= 32'h0;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= 32'h0;
                        if (mem_we_q) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b0;
                            resp_data_q  <= 32'h0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (timed_out) begin
                        mem_req_q    <= 1'b0;
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_data_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_data_q  <= load_d;
                    end else if (timed_out) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_data_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_data_q  <= 32'h0;
                    cnt_q        <= 32'h0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
